// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch path: instruction width,
// sequential PC step and the word-alignment mask applied to redirect targets.
package fetch_unit_pkg;

    localparam int INSTR_W    = 32;
    localparam int PC_INC     = 4;
    localparam int ALIGN_MASK = 3;

endpackage

// File: rtl/fetch_unit_queue.sv
// Circular fetch queue: power-of-two entries, single push/pop per cycle,
// flush empties it in one cycle. Only pointers and count are reset.
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Payload storage carries no reset; validity lives entirely in count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues sequential ROM reads, buffers the
// responses with their PCs, and flushes/refetches on a redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = ADDR_W + INSTR_W;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic [CNT_W-1:0]  count;
    logic [ENT_W-1:0]  head_data;
    logic              full;
    logic              empty;
    logic              issue;
    logic              push;
    logic              pop;

    // Inflight reads are reserved against queue space so a response always fits.
    assign issue = !rst && !redirect_valid && !full &&
                   (({1'b0, count} + (CNT_W + 1)'(inflight)) < (CNT_W + 1)'(DEPTH));

    assign imem_req  = issue;
    assign imem_addr = fetch_pc;
    assign push      = inflight && !redirect_valid;
    assign out_valid = !empty && !rst;
    assign pop       = out_valid && out_ready;
    assign out_pc    = head_data[ENT_W-1:INSTR_W];
    assign out_instr = head_data[INSTR_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            inflight <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & ~ADDR_W'(ALIGN_MASK);
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) fetch_pc <= fetch_pc + ADDR_W'(PC_INC);
        end
    end

    always_ff @(posedge clk) begin
        if (issue) inflight_pc <= fetch_pc;
    end

    fetch_queue #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ({inflight_pc, imem_rdata}),
        .pop       (pop),
        .head_data (head_data),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: an address-stream model checked every
// cycle, plus directed literal expectations for the key scenarios.
module tb_fetch_unit;

    localparam int          ADDR_W   = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0400;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    function automatic logic [31:0] rom(input logic [31:0] addr);
        return (addr * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    always @(posedge clk) begin
        if (imem_req) imem_rdata <= rom(imem_addr);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: list of fetched-but-unconsumed addresses with their issue cycle.
    typedef struct {
        logic [31:0] addr;
        int          t;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    int          cyc = 0;
    bit          exp_valid;
    bit          exp_req;

    always @(negedge clk) begin
        if (rst) begin
            checkOutput("rst_req", {31'b0, imem_req}, 32'd0);
            checkOutput("rst_valid", {31'b0, out_valid}, 32'd0);
            mq.delete();
            m_pc = RESET_PC;
        end else begin
            exp_valid = 1'b0;
            if (mq.size() > 0) exp_valid = (cyc - mq[0].t) >= 2;
            exp_req = !redirect_valid && (mq.size() < DEPTH);
            checkOutput("model_req", {31'b0, imem_req}, {31'b0, exp_req});
            checkOutput("model_addr", imem_addr, m_pc);
            checkOutput("model_valid", {31'b0, out_valid}, {31'b0, exp_valid});
            if (exp_valid) begin
                checkOutput("model_out_pc", out_pc, mq[0].addr);
                checkOutput("model_out_instr", out_instr, rom(mq[0].addr));
            end
            if (redirect_valid) begin
                mq.delete();
                m_pc = redirect_pc & ~32'h3;
            end else begin
                if (exp_valid && out_ready) void'(mq.pop_front());
                if (exp_req) begin
                    mq.push_back('{m_pc, cyc});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        cyc++;
    end

    // Drives one cycle of inputs just after the edge, returns at the next negedge.
    task automatic applyStimulus(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        @(posedge clk);
        #1;
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        @(negedge clk);
    endtask

    int          reqs;
    logic [23:0] ready_pat;
    logic [31:0] wrap_addr [5];
    logic [31:0] wrap_pc   [5];

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;
        ready_pat      = 24'b1011_0010_0111_0001_1100_1010;
        wrap_addr      = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
        wrap_pc        = '{32'h0, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};

        repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("reset_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset_req", {31'b0, imem_req}, 32'd0);

        // Reset release: sequential fetch, two-cycle latency, full throughput
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("c1_req", {31'b0, imem_req}, 32'd1);
        checkOutput("c1_addr", imem_addr, 32'h400);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("c2_addr", imem_addr, 32'h404);
        checkOutput("c2_valid", {31'b0, out_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("c3_addr", imem_addr, 32'h408);
        checkOutput("c3_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("c3_out_pc", out_pc, 32'h400);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
            checkOutput("stream_out_pc", out_pc, 32'h404 + 32'(4 * i));
        end

        // Stall: exactly DEPTH requests, then ordered drain and resume
        repeat (2) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        reqs = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
            if (imem_req) reqs++;
        end
        checkOutput("stall_reqs", 32'(reqs), 32'd4);
        checkOutput("stall_req_low", {31'b0, imem_req}, 32'd0);
        checkOutput("stall_head", out_pc, 32'h400);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
            checkOutput("drain_out_pc", out_pc, 32'h400 + 32'(4 * i));
            if (i == 0) checkOutput("drain_next_addr", imem_addr, 32'h410);
            if (i == 1) checkOutput("drain_resume_req", {31'b0, imem_req}, 32'd1);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("drain_resume_pc", out_pc, 32'h410);

        // Redirect with 3 queued entries and one inflight
        repeat (2) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h1003, 1'b0);
        checkOutput("redir_no_issue", {31'b0, imem_req}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("redir_valid_low", {31'b0, out_valid}, 32'd0);
        checkOutput("redir_addr", imem_addr, 32'h1000);
        checkOutput("redir_req", {31'b0, imem_req}, 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("redir_valid_low2", {31'b0, out_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("redir_first_pc", out_pc, 32'h1000);
        repeat (2) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect coinciding with pop and push
        applyStimulus(1'b0, 1'b1, 32'h2000, 1'b1);
        checkOutput("rpp_valid_before", {31'b0, out_valid}, 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("rpp_valid_after", {31'b0, out_valid}, 32'd0);
        checkOutput("rpp_addr", imem_addr, 32'h2000);
        repeat (2) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("rpp_out_pc", out_pc, 32'h2000);

        // Back-to-back redirects: last target wins
        applyStimulus(1'b0, 1'b1, 32'h3000, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h5009, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("b2b_addr", imem_addr, 32'h5008);
        checkOutput("b2b_valid", {31'b0, out_valid}, 32'd0);
        repeat (2) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("b2b_out_pc", out_pc, 32'h5008);

        // Address wrap through zero
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF9, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
            checkOutput("wrap_addr", imem_addr, wrap_addr[i]);
            if (i >= 2) checkOutput("wrap_out_pc", out_pc, wrap_pc[i]);
        end

        // Irregular decode back-pressure, checked by the model
        for (int i = 0; i < 24; i++) applyStimulus(1'b0, 1'b0, 32'h0, ready_pat[i]);

        // Reset (with a redirect pending) while the queue is full
        repeat (6) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("full_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("full_no_req", {31'b0, imem_req}, 32'd0);
        applyStimulus(1'b1, 1'b1, 32'h7000, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("rstfull_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rstfull_addr", imem_addr, 32'h400);
        checkOutput("rstfull_req", {31'b0, imem_req}, 32'd1);
        repeat (2) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("rstfull_out_pc", out_pc, 32'h400);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
